// File: rtl/vector_packer_if.sv
// Stream bundle between a narrow beat producer, the packer and a wide word consumer.
// Latency: none, this is wiring only.
// Backpressure: in_ready gates the beat side and out_ready gates the word side.
// Ports: in_valid/in_ready/in_data/in_last carry beats into the packer;
//        out_valid/out_ready/out_data/out_count carry packed words out of it.
// The slave modport is the packer's view. The master modport is the producer/consumer view.
interface vector_packer_if #(
    parameter int IN_W  = 4,
    parameter int RATIO = 2
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = $clog2(RATIO + 1);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/vector_packer.sv
// Packs RATIO narrow IN_W-bit beats into one wide word, with an early flush on in_last.
// Latency: the word is valid one cycle after its closing beat is accepted.
// Backpressure: while a word is held, in_ready follows out_ready, so a simultaneous handshake
//               runs at full rate with no bubble.
// Ports: clk, and rst (synchronous, active-high).
//        bus (vector_packer_if.slave) carries the beat and word handshakes, out_count
//        (the number of filled slices, 1..RATIO) and the packed out_data.
module vector_packer #(
    parameter int IN_W      = 4,
    parameter int RATIO     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    vector_packer_if.slave  bus
);
    localparam int OUT_W  = IN_W * RATIO;
    localparam int SLOT_W = $clog2(RATIO);
    localparam int CNT_W  = $clog2(RATIO + 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]        state;
    logic [SLOT_W-1:0] slot;
    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  out_data_q;
    logic [CNT_W-1:0]  out_count_q;

    logic              in_ready_int;
    logic              accept;
    logic              closes;
    logic [OUT_W-1:0]  placed;
    logic [OUT_W-1:0]  word;

    // A held word frees the slot only when the consumer takes it in the same edge.
    assign in_ready_int = ~rst & ((state == ST_FILL) | bus.out_ready);
    assign accept       = bus.in_valid & in_ready_int;

    // Place the incoming beat in the slice owned by the current slot. All other bits are zero.
    always_comb begin
        placed = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (slot == SLOT_W'(k)) begin
                if (MSB_FIRST) begin
                    placed[OUT_W-1-k*IN_W -: IN_W] = bus.in_data;
                end else begin
                    placed[k*IN_W +: IN_W] = bus.in_data;
                end
            end
        end
    end

    // In HOLD both acc and slot are already zero, so an accepted beat there
    // naturally starts a fresh word at slot 0.
    assign word   = acc | placed;
    assign closes = bus.in_last | (slot == SLOT_W'(RATIO - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FILL;
            slot        <= '0;
            acc         <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else if (accept) begin
            if (closes) begin
                state       <= ST_HOLD;
                slot        <= '0;
                acc         <= '0;
                out_data_q  <= word;
                out_count_q <= CNT_W'(slot) + CNT_W'(1);
            end else begin
                state <= ST_FILL;
                slot  <= slot + SLOT_W'(1);
                acc   <= word;
            end
        end else if ((state == ST_HOLD) && bus.out_ready) begin
            state <= ST_FILL;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = (state == ST_HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_vector_packer.sv
// Directed bench for vector_packer: a table of per-cycle vectors on an MSB-first 4x2 packer,
// plus hand sequences on an LSB-first 4x2 packer and an LSB-first 8x4 packer.
// Expected values are hand-computed constants.
module tb_vector_packer;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_bc;

    always #5 clk = ~clk;

    vector_packer_if #(.IN_W(4), .RATIO(2)) if_a ();
    vector_packer_if #(.IN_W(4), .RATIO(2)) if_b ();
    vector_packer_if #(.IN_W(8), .RATIO(4)) if_c ();

    vector_packer #(.IN_W(4), .RATIO(2), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst_a),  .bus(if_a));
    vector_packer #(.IN_W(4), .RATIO(2), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst_bc), .bus(if_b));
    vector_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0)) dut_c (.clk(clk), .rst(rst_bc), .bus(if_c));

    typedef struct {
        logic       rst;
        logic       v;
        logic [3:0] d;
        logic       l;
        logic       ordy;
        logic       e_irdy;   // in_ready before the edge
        logic       e_ov;     // out_valid after the edge
        logic       chk;      // also check data/count after the edge
        logic [7:0] e_od;
        logic [1:0] e_oc;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] d, input logic l,
                                input logic ordy, input logic e_irdy, input logic e_ov,
                                input logic chk, input logic [7:0] e_od, input logic [1:0] e_oc);
        vec_t t;
        t.rst = r; t.v = v; t.d = d; t.l = l; t.ordy = ordy;
        t.e_irdy = e_irdy; t.e_ov = e_ov; t.chk = chk; t.e_od = e_od; t.e_oc = e_oc;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a  = 1'b1;
        rst_bc = 1'b1;
        if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.in_last = 1'b0; if_a.out_ready = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.in_last = 1'b0; if_b.out_ready = 1'b0;
        if_c.in_valid = 1'b0; if_c.in_data = '0; if_c.in_last = 1'b0; if_c.out_ready = 1'b0;

        // reset
        tbl.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0, 1, 8'h00, 2'd0));
        // back-to-back A,5 -> A5
        tbl.push_back(mk(0, 1, 4'hA, 0, 0, 1, 0, 0, 8'h00, 2'd0));
        tbl.push_back(mk(0, 1, 4'h5, 0, 0, 1, 1, 1, 8'hA5, 2'd2));
        // backpressure: 5 cycles held, offered beats not taken
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 1, 4'hF, 0, 0, 0, 1, 1, 8'hA5, 2'd2));
        // release: exactly one transfer
        tbl.push_back(mk(0, 0, 4'h0, 0, 1, 1, 0, 0, 8'h00, 2'd0));
        tbl.push_back(mk(0, 0, 4'h0, 0, 1, 1, 0, 0, 8'h00, 2'd0));
        // flush of a partial word
        tbl.push_back(mk(0, 1, 4'hA, 1, 0, 1, 1, 1, 8'hA0, 2'd1));
        tbl.push_back(mk(0, 0, 4'h0, 0, 1, 1, 0, 0, 8'h00, 2'd0));
        // throughput: beats 1..8 -> 12,34,56,78
        for (int b = 1; b <= 8; b++) begin
            logic [3:0] hi;
            logic [3:0] lo;
            hi = 4'(b - 1);
            lo = 4'(b);
            tbl.push_back(mk(0, 1, lo, 0, 1, 1, (b % 2 == 0), (b % 2 == 0), {hi, lo}, 2'd2));
        end
        tbl.push_back(mk(0, 0, 4'h0, 0, 1, 1, 0, 0, 8'h00, 2'd0));
        // handshake on a held word with an in_last beat: straight back to HOLD
        tbl.push_back(mk(0, 1, 4'h9, 0, 1, 1, 0, 0, 8'h00, 2'd0));
        tbl.push_back(mk(0, 1, 4'hB, 0, 1, 1, 1, 1, 8'h9B, 2'd2));
        tbl.push_back(mk(0, 1, 4'hC, 1, 1, 1, 1, 1, 8'hC0, 2'd1));
        tbl.push_back(mk(0, 0, 4'h0, 0, 1, 1, 0, 0, 8'h00, 2'd0));
        // reset mid-word discards C
        tbl.push_back(mk(0, 1, 4'hC, 0, 1, 1, 0, 0, 8'h00, 2'd0));
        tbl.push_back(mk(1, 0, 4'h0, 0, 1, 0, 0, 1, 8'h00, 2'd0));
        tbl.push_back(mk(0, 1, 4'h3, 0, 1, 1, 0, 0, 8'h00, 2'd0));
        tbl.push_back(mk(0, 1, 4'h4, 0, 1, 1, 1, 1, 8'h34, 2'd2));
        tbl.push_back(mk(0, 0, 4'h0, 0, 1, 1, 0, 0, 8'h00, 2'd0));
        // reset while a word is held discards it
        tbl.push_back(mk(0, 1, 4'h7, 0, 0, 1, 0, 0, 8'h00, 2'd0));
        tbl.push_back(mk(0, 1, 4'h7, 0, 0, 1, 1, 1, 8'h77, 2'd2));
        tbl.push_back(mk(1, 1, 4'h1, 0, 0, 0, 0, 1, 8'h00, 2'd0));
        tbl.push_back(mk(0, 0, 4'h0, 0, 1, 1, 0, 0, 8'h00, 2'd0));
        tbl.push_back(mk(0, 0, 4'h0, 0, 1, 1, 0, 0, 8'h00, 2'd0));

        tick();
        foreach (tbl[i]) begin
            rst_a          = tbl[i].rst;
            if_a.in_valid  = tbl[i].v;
            if_a.in_data   = tbl[i].d;
            if_a.in_last   = tbl[i].l;
            if_a.out_ready = tbl[i].ordy;
            #1;
            check($sformatf("row%0d in_ready", i), 32'(if_a.in_ready), 32'(tbl[i].e_irdy));
            tick();
            check($sformatf("row%0d out_valid", i), 32'(if_a.out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].chk) begin
                check($sformatf("row%0d out_data", i), 32'(if_a.out_data), 32'(tbl[i].e_od));
                check($sformatf("row%0d out_count", i), 32'(if_a.out_count), 32'(tbl[i].e_oc));
            end
        end
        if_a.in_valid = 1'b0;

        // LSB-first 4x2: A,5 -> 5A, then flush A -> 0A
        rst_bc = 1'b0;
        tick();
        if_b.in_valid = 1'b1; if_b.in_data = 4'hA;
        tick();
        check("b first beat no word", 32'(if_b.out_valid), 32'd0);
        if_b.in_data = 4'h5;
        tick();
        check("b full valid", 32'(if_b.out_valid), 32'd1);
        check("b full data", 32'(if_b.out_data), 32'h5A);
        check("b full count", 32'(if_b.out_count), 32'd2);
        if_b.in_valid = 1'b0; if_b.out_ready = 1'b1;
        tick();
        check("b consumed", 32'(if_b.out_valid), 32'd0);
        if_b.in_valid = 1'b1; if_b.in_data = 4'hA; if_b.in_last = 1'b1; if_b.out_ready = 1'b0;
        tick();
        check("b flush valid", 32'(if_b.out_valid), 32'd1);
        check("b flush data", 32'(if_b.out_data), 32'h0A);
        check("b flush count", 32'(if_b.out_count), 32'd1);
        if_b.in_valid = 1'b0; if_b.in_last = 1'b0; if_b.out_ready = 1'b1;
        tick();
        check("b flush consumed", 32'(if_b.out_valid), 32'd0);

        // LSB-first 8x4: 11,22,33(last) -> 00332211, count 3
        if_c.in_valid = 1'b1; if_c.out_ready = 1'b0;
        if_c.in_data = 8'h11;
        tick();
        if_c.in_data = 8'h22;
        tick();
        if_c.in_data = 8'h33; if_c.in_last = 1'b1;
        #1;
        check("c pre-word valid", 32'(if_c.out_valid), 32'd0);
        tick();
        check("c partial valid", 32'(if_c.out_valid), 32'd1);
        check("c partial data", 32'(if_c.out_data), 32'h00332211);
        check("c partial count", 32'(if_c.out_count), 32'd3);
        // the next word: 01,02,03 then 04 with in_last -> one full word of count 4
        if_c.out_ready = 1'b1; if_c.in_last = 1'b0; if_c.in_data = 8'h01;
        tick();
        check("c consumed", 32'(if_c.out_valid), 32'd0);
        if_c.in_data = 8'h02;
        tick();
        if_c.in_data = 8'h03;
        tick();
        if_c.in_data = 8'h04; if_c.in_last = 1'b1;
        tick();
        check("c full valid", 32'(if_c.out_valid), 32'd1);
        check("c full data", 32'(if_c.out_data), 32'h04030201);
        check("c full count", 32'(if_c.out_count), 32'd4);
        if_c.in_valid = 1'b0; if_c.in_last = 1'b0;
        tick();
        check("c full consumed", 32'(if_c.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
